vjtag_bus_arbiter: RTL and testbench
====================================

// Module: vjtag_bus_arbiter
// PURPOSE
//  Shares one register-bus slave (GPIO register bank) between NM bus masters (VJTAG host, local master).
//  Round-robin grant; one transaction outstanding at a time; the winning request's command is latched.
//  Slave timeout returns an error response so a missing slave ack never hangs a master.
//  Sits between the vjtag host / local masters and the GPIO register block inside fpga_vjtag2gpio.
// PARAMETERS
//  NM       2    number of masters (>=2); master 0 = VJTAG host
//  AW       16   address width
//  DW       32   data width
//  TIMEOUT  64   BUSY cycles without s_ack before error response (>=2)
// PORTS
//  clk        in   1      system clock; single clock domain
//  rst        in   1      synchronous reset, active-high
//  m_req      in   NM     per-master request; held with command until its m_ack
//  m_write    in   NM     1=write, 0=read
//  m_addr     in   NM*AW  flattened; master i at [i*AW +: AW]
//  m_wdata    in   NM*DW  flattened write data
//  m_ack      out  NM     one-cycle completion pulse to granted master
//  m_err      out  1      qualifies m_ack: 1=timeout
//  m_rdata    out  DW     read data, valid with m_ack (shared by all masters)
//  s_req      out  1      slave request, held high until s_ack or timeout
//  s_write    out  1      latched command
//  s_addr     out  AW     latched command
//  s_wdata    out  DW     latched command
//  s_ack      in   1      slave completion; s_rdata valid same cycle
//  s_rdata    in   DW     slave read data
//  busy       out  1      1 when state != IDLE
//  err_cnt    out  8      saturating count of timeouts
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr pointer=0 (master 0 highest priority); err_cnt=0; timer=0.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: any m_req -> pick winner: first requester at or after ptr, wrapping NM-1 -> 0.
//        Latch grant idx, write, addr, wdata; go BUSY. No request -> stay.
//  BUSY: s_req=1, command regs stable. Timer increments each BUSY cycle.
//        s_ack=1 -> capture s_rdata, err=0, go RESP.
//        timer==TIMEOUT-1 and no s_ack -> rdata=0, err=1, err_cnt+1 (saturate 255), go RESP.
//        s_ack and timeout in same cycle -> ack wins (err=0).
//  RESP: m_ack[grant]=1 for exactly one cycle with m_err/m_rdata; s_req=0; ptr=(grant+1) mod NM; timer=0; go IDLE.
//  Latency: request seen in IDLE at cycle t -> s_req at t+1; s_ack at cycle u -> m_ack at u+1.
//        Minimum 3 cycles, request to m_ack.
//  Writes: m_rdata=0 on ack. m_rdata/m_err hold their last value outside m_ack (don't-care).
//  Masters drop m_req the cycle after m_ack unless issuing a new transaction.
//        A request that is high in IDLE is always treated as new.
//  s_ack outside BUSY is ignored. m_req changes from non-granted masters never disturb BUSY/RESP.
//  Fairness: with all masters requesting continuously, grants rotate 0,1,..,NM-1,0.
//  Reset mid-transaction: next cycle IDLE, s_req=0, no m_ack issued, ptr=0; err_cnt cleared.
// STRUCTURE
//  vjtag_bus_pkg: state enum (IDLE/BUSY/RESP), default AW/DW constants, timeout-counter width function.
//  Sub-module vjtag_rr_pick (combinational): req[NM] + ptr -> onehot grant + index + any.
//        Uses a double-width rotate mask.
//  Top: FSM, command/response regs, timer, err_cnt.
// TESTING
//  1 Single read: m0 reads 0x0010, slave acks after 3 cycles with 0xCAFE0001
//        -> m_ack[0] 1 cycle later, m_rdata=0xCAFE0001, m_err=0.
//  2 Contention: m0,m1 request same cycle after reset -> m0 served first, then m1.
//        Both stay high -> grants 0,1,0,1.
//  3 Timeout: slave never acks -> s_req high exactly 64 cycles.
//        m_ack with m_err=1, m_rdata=0, err_cnt=1; repeat 300x -> err_cnt saturates at 255.
//  4 Boundary: s_ack on the 64th BUSY cycle -> normal ack, err=0, err_cnt unchanged.
//        Stray s_ack in IDLE -> no m_ack.
//  5 Reset mid-BUSY: assert rst during write to 0x0004 -> s_req=0 next cycle.
//        No m_ack; m1 requesting after reset is granted only when m0 is idle.
//  6 Command stability: m0 changes m_addr while its transaction is in BUSY -> s_addr holds the latched value.
//        Random scoreboard: 1000 mixed transactions, every request gets exactly one ack.

Source files
------------

// File: rtl/vjtag_bus_arbiter_pkg.sv
// Shared types and constants for the VJTAG register-bus arbiter.
// Holds the FSM state type, default bus widths and the timer width helper.
package vjtag_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned DefAw      = 16;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned DefTimeout = 64;
  localparam logic [7:0]  ErrCntMax  = 8'hFF;

  // Bits needed for a counter that runs 0 .. timeout-1.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/vjtag_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Outputs a one-hot grant, its index and whether any request is present.
module vjtag_bus_arbiter_rr_pick #(
  parameter int unsigned NM = 2,
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [IW:0] NmW = (IW + 1)'(NM);

  logic [2*NM-1:0] dbl;
  logic [NM-1:0]   rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  always_comb begin
    // rot[k] is the request of master (ptr + k) mod NM.
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NM-1:0];
    off = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IW'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NmW) begin
      sum = sum - NmW;
    end
    idx_o = sum[IW-1:0];
    any_o = |req_i;
    gnt_o = any_o ? (NM'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/vjtag_bus_arbiter.sv
// Shares one register-bus slave between NM masters with round-robin grant,
// one outstanding transaction and a slave-ack timeout that returns an error.
module vjtag_bus_arbiter
  import vjtag_bus_arbiter_pkg::*;
#(
  parameter int unsigned NM      = 2,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NM-1:0]     m_req_i,
  input  logic [NM-1:0]     m_write_i,
  input  logic [NM*AW-1:0]  m_addr_i,
  input  logic [NM*DW-1:0]  m_wdata_i,
  output logic [NM-1:0]     m_ack_o,
  output logic              m_err_o,
  output logic [DW-1:0]     m_rdata_o,
  output logic              s_req_o,
  output logic              s_write_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_wdata_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_rdata_i,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [NM-1:0] gnt_q, gnt_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          timeout;

  vjtag_bus_arbiter_rr_pick #(
    .NM (NM)
  ) u_rr_pick (
    .req_i (m_req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // An ack on the last allowed cycle still wins over the timeout.
  assign timeout = (state_q == StBusy) && (timer_q == TimerLast) && !s_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StBusy;
      StBusy:  if (s_ack_i || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_ack_o = '0;
    s_req_o = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      StIdle:  busy_o  = 1'b0;
      StBusy:  s_req_o = 1'b1;
      StResp:  m_ack_o = gnt_q;
      default: busy_o  = 1'b0;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          write_d = m_write_i[pick_idx];
          addr_d  = m_addr_i[pick_idx*AW +: AW];
          wdata_d = m_wdata_i[pick_idx*DW +: DW];
        end
      end
      StBusy: begin
        timer_d = timer_q + 1'b1;
        if (s_ack_i) begin
          rdata_d = write_q ? '0 : s_rdata_i;
          err_d   = 1'b0;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          if (err_cnt_q != ErrCntMax) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      StResp: begin
        timer_d = '0;
        ptr_d   = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_write_o = write_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;
  assign err_cnt_o = err_cnt_q;

  ack_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(m_ack_o));
  sreq_busy_a:  assert property (@(posedge clk_i) disable iff (rst_i) s_req_o |-> busy_o);

endmodule

// File: tb/tb_vjtag_bus_arbiter.sv
// Randomized bench for vjtag_bus_arbiter with a transaction-level reference model.
module tb_vjtag_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TIMEOUT = 64;

  localparam int PhFree = 0;
  localparam int PhWait = 1;
  localparam int PhDone = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM-1:0]     m_req = '0;
  logic [NM-1:0]     m_write = '0;
  logic [NM*AW-1:0]  m_addr = '0;
  logic [NM*DW-1:0]  m_wdata = '0;
  logic [NM-1:0]     m_ack;
  logic              m_err;
  logic [DW-1:0]     m_rdata;
  logic              s_req;
  logic              s_write;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic              s_ack = 1'b0;
  logic [DW-1:0]     s_rdata = '0;
  logic              busy;
  logic [7:0]        err_cnt;

  vjtag_bus_arbiter #(
    .NM      (NM),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_req_i   (m_req),
    .m_write_i (m_write),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_rdata_o (m_rdata),
    .s_req_o   (s_req),
    .s_write_o (s_write),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_ack_i   (s_ack),
    .s_rdata_i (s_rdata),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one bus owner at a time, described in transaction terms.
  int            ref_phase = PhFree;
  int            ref_owner = 0;
  int            ref_ptr = 0;
  int            ref_waited = 0;
  int            ref_errs = 0;
  int            ref_acks = 0;
  bit            ref_after_rst = 0;
  logic          ref_wr = 1'b0;
  logic [AW-1:0] ref_addr = '0;
  logic [DW-1:0] ref_wdata = '0;
  logic [DW-1:0] ref_rdata = '0;
  logic          ref_err = 1'b0;

  // Stimulus knobs
  logic [NM-1:0] active = '0;
  int            p_new = 0, p_dead = 0, p_stray = 0, p_scr = 0;
  int            lat_min = 1, lat_max = 1, cur_lat = 1;
  bit            use_fixed = 0;
  logic [DW-1:0] fixed_rd = '0;
  int            issued[NM];
  int            obs_acks[NM];
  int            sreq_run = 0, last_run = 0;

  function automatic int pick(input logic [NM-1:0] req, input int ptr);
    for (int k = 0; k < NM; k++) begin
      if (req[(ptr + k) % NM]) return (ptr + k) % NM;
    end
    return -1;
  endfunction

  function automatic int pct();
    return int'($urandom_range(0, 99));
  endfunction

  task automatic model_step();
    int w;
    ref_after_rst = 0;
    if (rst) begin
      ref_phase = PhFree;
      ref_ptr = 0;
      ref_errs = 0;
      ref_after_rst = 1;
      return;
    end
    case (ref_phase)
      PhFree: begin
        w = pick(m_req, ref_ptr);
        if (w >= 0) begin
          ref_owner  = w;
          ref_wr     = m_write[w];
          ref_addr   = m_addr[w*AW +: AW];
          ref_wdata  = m_wdata[w*DW +: DW];
          ref_waited = 0;
          ref_phase  = PhWait;
        end
      end
      PhWait: begin
        ref_waited++;
        if (s_ack) begin
          ref_rdata = ref_wr ? '0 : s_rdata;
          ref_err   = 1'b0;
          ref_phase = PhDone;
          ref_acks++;
        end else if (ref_waited == TIMEOUT) begin
          ref_rdata = '0;
          ref_err   = 1'b1;
          if (ref_errs < 255) ref_errs++;
          ref_phase = PhDone;
          ref_acks++;
        end
      end
      default: begin
        ref_ptr   = (ref_owner + 1) % NM;
        ref_phase = PhFree;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("busy", busy, ref_phase != PhFree);
    check_eq("s_req", s_req, ref_phase == PhWait);
    check_eq("m_ack", m_ack, (ref_phase == PhDone) ? (1 << ref_owner) : 0);
    check_eq("err_cnt", err_cnt, ref_errs);
    if (ref_phase == PhWait) begin
      check_eq("s_addr", s_addr, ref_addr);
      check_eq("s_write", s_write, ref_wr);
      check_eq("s_wdata", s_wdata, ref_wdata);
    end
    if (ref_phase == PhDone) begin
      check_eq("m_err", m_err, ref_err);
      check_eq("m_rdata", m_rdata, ref_rdata);
    end
    if (ref_after_rst) begin
      check_eq("rst_m_rdata", m_rdata, 0);
      check_eq("rst_m_err", m_err, 0);
      check_eq("rst_s_cmd", {s_write, s_addr, s_wdata}, 0);
    end
    for (int i = 0; i < NM; i++) obs_acks[i] += int'(m_ack[i]);
    if (s_req) begin
      sreq_run++;
    end else if (sreq_run > 0) begin
      last_run = sreq_run;
      sreq_run = 0;
    end
  endtask

  task automatic new_cmd(input int i);
    m_req[i]              = 1'b1;
    m_write[i]            = 1'($urandom_range(0, 1));
    m_addr[i*AW +: AW]    = AW'($urandom);
    m_wdata[i*DW +: DW]   = DW'($urandom);
    issued[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      if (m_req[i] && ref_phase == PhDone && ref_owner == i) begin
        if (active[i] && pct() < p_new) new_cmd(i);
        else m_req[i] = 1'b0;
      end else if (!m_req[i] && active[i] && pct() < p_new) begin
        new_cmd(i);
      end
    end
    if (ref_phase == PhWait && pct() < p_scr) begin
      m_write[ref_owner]                = ~m_write[ref_owner];
      m_addr[ref_owner*AW +: AW]        = AW'($urandom);
      m_wdata[ref_owner*DW +: DW]       = DW'($urandom);
    end
    if (ref_phase == PhWait && ref_waited == 0) begin
      cur_lat = (pct() < p_dead) ? 0 : int'($urandom_range(lat_min, lat_max));
    end
    s_ack = 1'b0;
    if (ref_phase == PhWait) s_ack = (cur_lat != 0) && (ref_waited + 1 == cur_lat);
    else if (pct() < p_stray) s_ack = 1'b1;
    s_rdata = use_fixed ? fixed_rd : DW'($urandom);
  endtask

  task automatic run_acks(input int n, input int budget);
    int target = ref_acks + n;
    int cyc = 0;
    while (ref_acks < target && cyc < budget) begin
      tick();
      drive();
      cyc++;
    end
    check_eq("acks_in_budget", ref_acks, target);
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    active = '0;
    p_new = 0;
    while ((m_req != 0 || ref_phase != PhFree) && cyc < budget) begin
      tick();
      drive();
      cyc++;
    end
    check_eq("drained_req", m_req, 0);
    check_eq("drained_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    int grants[$];
    int acks_before;
    for (int i = 0; i < NM; i++) begin
      issued[i] = 0;
      obs_acks[i] = 0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) begin
      tick();
      drive();
    end
    rst = 1'b0;

    // Single read, slave acks on its 3rd BUSY cycle
    use_fixed = 1;
    fixed_rd = 32'hCAFE_0001;
    lat_min = 3;
    lat_max = 3;
    s_rdata = fixed_rd;
    m_req[0] = 1'b1;
    m_write[0] = 1'b0;
    m_addr[0 +: AW] = 16'h0010;
    cyc = 0;
    while (m_ack[0] !== 1'b1 && cyc < 20) begin
      tick();
      drive();
      cyc++;
    end
    check_eq("rd_latency", cyc, 4);
    check_eq("rd_data", m_rdata, 32'hCAFE_0001);
    check_eq("rd_err", m_err, 0);
    use_fixed = 0;
    drain(20);

    // Contention right after reset: grants alternate starting with m0
    rst = 1'b1;
    tick();
    drive();
    rst = 1'b0;
    active = 2'b11;
    p_new = 100;
    lat_min = 1;
    lat_max = 2;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (m_ack == 0 && cyc < 20) begin
        tick();
        drive();
        cyc++;
      end
      grants.push_back(m_ack[1] ? 1 : 0);
      if (m_ack == 0) grants[t] = -1;
      tick();
      drive();
    end
    for (int t = 0; t < 4; t++) check_eq($sformatf("grant_order_%0d", t), grants[t], t % 2);
    drain(50);

    // Timeouts: dead slave, err_cnt saturates at 255
    active = 2'b01;
    p_new = 100;
    p_dead = 100;
    for (int t = 1; t <= 300; t++) begin
      run_acks(1, 200);
      if (t == 1) begin
        check_eq("timeout_sreq_len", last_run, TIMEOUT);
        check_eq("timeout_err_cnt1", err_cnt, 1);
        check_eq("timeout_rdata", m_rdata, 0);
        check_eq("timeout_err", m_err, 1);
      end
    end
    check_eq("err_cnt_sat", err_cnt, 255);
    drain(200);

    // Ack on the last allowed BUSY cycle wins over the timeout
    p_dead = 0;
    lat_min = TIMEOUT;
    lat_max = TIMEOUT;
    m_req[0] = 1'b1;
    m_write[0] = 1'b0;
    run_acks(1, 100);
    check_eq("boundary_err", m_err, 0);
    check_eq("boundary_err_cnt", err_cnt, 255);
    drain(20);

    // Stray slave acks while idle produce nothing
    p_stray = 100;
    acks_before = obs_acks[0] + obs_acks[1];
    repeat (10) begin
      tick();
      drive();
    end
    check_eq("stray_acks", obs_acks[0] + obs_acks[1], acks_before);
    p_stray = 0;

    // Reset in the middle of a write to 0x0004
    p_dead = 100;
    m_req[0] = 1'b1;
    m_write[0] = 1'b1;
    m_addr[0 +: AW] = 16'h0004;
    repeat (6) begin
      tick();
      drive();
    end
    m_req[1] = 1'b1;
    rst = 1'b1;
    tick();
    drive();
    rst = 1'b0;
    check_eq("rst_sreq", s_req, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    p_dead = 0;
    lat_min = 2;
    lat_max = 2;
    cyc = 0;
    while (m_ack == 0 && cyc < 20) begin
      tick();
      drive();
      cyc++;
    end
    check_eq("post_rst_first_grant", m_ack, 2'b01);
    drain(50);

    // Random traffic with command scrambling during BUSY
    for (int i = 0; i < NM; i++) begin
      issued[i] = 0;
      obs_acks[i] = 0;
    end
    active = 2'b11;
    p_new = 30;
    p_dead = 3;
    p_stray = 20;
    p_scr = 10;
    lat_min = 1;
    lat_max = 6;
    run_acks(1000, 40000);
    p_scr = 0;
    drain(500);
    for (int i = 0; i < NM; i++) check_eq($sformatf("acks_per_req_m%0d", i), obs_acks[i], issued[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
